// File: rtl/ofm_write_addr_controller.sv
// OFM RAM write-side address generator: drains one tile (num_filter row vectors) per load.
// Optional macro OFM_WR_BOUNDS_CHECK_EN adds a sticky addr_error_o and out-of-range write suppression.
module ofm_write_addr_controller #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_RAM_SIZE  = 2205619,
  localparam int AW = $clog2(OFM_RAM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] start_write_addr_i,
  input  logic          load_i,
  input  logic [8:0]    ofm_size_i,
  input  logic [4:0]    num_filter_i,
  output logic [AW-1:0] ofm_addr_o,
  output logic          write_en_o,
  output logic [4:0]    write_ofm_size_o,
  output logic [3:0]    write_ch_o,
  output logic [13:0]   count_tiling_o,
  output logic          tile_done_o,
  output logic          layer_done_o,
`ifdef OFM_WR_BOUNDS_CHECK_EN
  output logic          addr_error_o,
`endif
  output logic          busy_o
);

  // state       | meaning
  // IDLE        | waiting for load
  // WRITE       | one row vector per cycle, write_ch 0..num_filter-1
  // NEXT_TILING | tile_done, advance row/segment/tile address
  typedef enum logic [1:0] {IDLE, WRITE, NEXT_TILING} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic [AW-1:0] ch_stride_q, ch_stride_d;
  logic [AW-1:0] tile_addr_q, tile_addr_d;
  logic [AW-1:0] seg_base_q, seg_base_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]    ofm_size_q, ofm_size_d;
  logic [8:0]    row_q, row_d;
  logic [4:0]    nf_q, nf_d;
  logic [5:0]    tpl_q, tpl_d;
  logic [5:0]    seg_q, seg_d;
  logic [9:0]    seg_col_q, seg_col_d;
  logic [13:0]   num_tiling_q, num_tiling_d;
  logic [13:0]   count_q, count_d;
  logic [3:0]    ch_q, ch_d;
  logic [4:0]    wos_q, wos_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic          tile_done;
  logic          layer_done;
  logic [4:0]    nf_eff;
  logic [9:0]    tpl_calc;
  logic [14:0]   ntile_calc;
  logic [17:0]   stride_calc;
  logic [9:0]    last_width;

  assign nf_eff      = (nf_q == 5'd0) ? 5'd1 : nf_q;
  assign tpl_calc    = (10'(ofm_size_i) + 10'(SYSTOLIC_SIZE - 1)) / 10'(SYSTOLIC_SIZE);
  assign ntile_calc  = 15'(tpl_calc) * 15'(ofm_size_i);
  assign stride_calc = 18'(ofm_size_i) * 18'(ofm_size_i);
  assign last_width  = 10'(ofm_size_q) - seg_col_q;

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    ch_stride_d  = ch_stride_q;
    tile_addr_d  = tile_addr_q;
    seg_base_d   = seg_base_q;
    wr_addr_d    = wr_addr_q;
    ofm_size_d   = ofm_size_q;
    row_d        = row_q;
    nf_d         = nf_q;
    tpl_d        = tpl_q;
    seg_d        = seg_q;
    seg_col_d    = seg_col_q;
    num_tiling_d = num_tiling_q;
    count_d      = count_q;
    ch_d         = ch_q;
    wos_d        = wos_q;
    err_d        = err_q;
    wr_en        = 1'b0;
    tile_done    = 1'b0;
    layer_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d   = WRITE;
          ch_d      = 4'd0;
          wr_addr_d = tile_addr_q;
          wos_d     = (7'(seg_q) + 7'd1 < 7'(tpl_q)) ? 5'(SYSTOLIC_SIZE) : last_width[4:0];
        end
      end
      WRITE: begin
        wr_en = 1'b1;
`ifdef OFM_WR_BOUNDS_CHECK_EN
        if (wr_addr_q >= AW'(OFM_RAM_SIZE)) begin
          wr_en = 1'b0;
          err_d = 1'b1;
        end
`endif
        if (5'(ch_q) == nf_eff - 5'd1) begin
          state_d = NEXT_TILING;
        end else begin
          ch_d      = ch_q + 4'd1;
          wr_addr_d = wr_addr_q + ch_stride_q;
        end
      end
      NEXT_TILING: begin
        tile_done = 1'b1;
        state_d   = IDLE;
        if (count_q == num_tiling_q) begin
          layer_done  = 1'b1;
          count_d     = 14'd1;
          row_d       = 9'd0;
          seg_d       = 6'd0;
          seg_col_d   = 10'd0;
          tile_addr_d = start_addr_q;
          seg_base_d  = start_addr_q;
        end else begin
          count_d = count_q + 14'd1;
          if (row_q == ofm_size_q - 9'd1) begin
            row_d       = 9'd0;
            seg_d       = seg_q + 6'd1;
            seg_col_d   = seg_col_q + 10'(SYSTOLIC_SIZE);
            tile_addr_d = seg_base_q + AW'(SYSTOLIC_SIZE);
            seg_base_d  = seg_base_q + AW'(SYSTOLIC_SIZE);
          end else begin
            row_d       = row_q + 9'd1;
            tile_addr_d = tile_addr_q + AW'(ofm_size_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // start overrides everything, including an in-flight tile
    if (start_i) begin
      state_d      = IDLE;
      start_addr_d = start_write_addr_i;
      ofm_size_d   = ofm_size_i;
      nf_d         = num_filter_i;
      tpl_d        = tpl_calc[5:0];
      num_tiling_d = ntile_calc[13:0];
      ch_stride_d  = AW'(stride_calc);
      tile_addr_d  = start_write_addr_i;
      seg_base_d   = start_write_addr_i;
      wr_addr_d    = start_write_addr_i;
      row_d        = 9'd0;
      seg_d        = 6'd0;
      seg_col_d    = 10'd0;
      count_d      = 14'd1;
      ch_d         = 4'd0;
      wos_d        = 5'd0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      ch_stride_q  <= '0;
      tile_addr_q  <= '0;
      seg_base_q   <= '0;
      wr_addr_q    <= '0;
      ofm_size_q   <= '0;
      row_q        <= '0;
      nf_q         <= '0;
      tpl_q        <= '0;
      seg_q        <= '0;
      seg_col_q    <= '0;
      num_tiling_q <= '0;
      count_q      <= 14'd1;
      ch_q         <= '0;
      wos_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      ch_stride_q  <= ch_stride_d;
      tile_addr_q  <= tile_addr_d;
      seg_base_q   <= seg_base_d;
      wr_addr_q    <= wr_addr_d;
      ofm_size_q   <= ofm_size_d;
      row_q        <= row_d;
      nf_q         <= nf_d;
      tpl_q        <= tpl_d;
      seg_q        <= seg_d;
      seg_col_q    <= seg_col_d;
      num_tiling_q <= num_tiling_d;
      count_q      <= count_d;
      ch_q         <= ch_d;
      wos_q        <= wos_d;
      err_q        <= err_d;
    end
  end

  assign ofm_addr_o       = wr_addr_q;
  assign write_en_o       = wr_en;
  assign write_ofm_size_o = wos_q;
  assign write_ch_o       = ch_q;
  assign count_tiling_o   = count_q;
  assign tile_done_o      = tile_done;
  assign layer_done_o     = layer_done;
  assign busy_o           = (state_q != IDLE);
`ifdef OFM_WR_BOUNDS_CHECK_EN
  assign addr_error_o     = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_ofm_write_addr_controller.sv
// Directed bench for ofm_write_addr_controller: vector table of tiles plus collision/reset sequences.
module tb_ofm_write_addr_controller;
  localparam int SS  = 16;
  localparam int RAM = 2205619;
  localparam int AW  = $clog2(RAM);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] start_write_addr_i;
  logic          load_i;
  logic [8:0]    ofm_size_i;
  logic [4:0]    num_filter_i;
  logic [AW-1:0] ofm_addr_o;
  logic          write_en_o;
  logic [4:0]    write_ofm_size_o;
  logic [3:0]    write_ch_o;
  logic [13:0]   count_tiling_o;
  logic          tile_done_o;
  logic          layer_done_o;
  logic          busy_o;
`ifdef OFM_WR_BOUNDS_CHECK_EN
  logic          addr_error_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ofm_write_addr_controller #(.SYSTOLIC_SIZE(SS), .OFM_RAM_SIZE(RAM)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .start_write_addr_i(start_write_addr_i),
    .load_i(load_i), .ofm_size_i(ofm_size_i), .num_filter_i(num_filter_i),
    .ofm_addr_o(ofm_addr_o), .write_en_o(write_en_o), .write_ofm_size_o(write_ofm_size_o),
    .write_ch_o(write_ch_o), .count_tiling_o(count_tiling_o), .tile_done_o(tile_done_o),
    .layer_done_o(layer_done_o),
`ifdef OFM_WR_BOUNDS_CHECK_EN
    .addr_error_o(addr_error_o),
`endif
    .busy_o(busy_o));

  typedef struct {
    int ofm; int saddr; int nf; int tile; int exp_addr; int exp_size; int exp_ld;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int ofm, input int saddr, input int nf);
    ofm_size_i         = 9'(ofm);
    start_write_addr_i = AW'(saddr);
    num_filter_i       = 5'(nf);
    start_i            = 1'b1;
    tick();
    start_i            = 1'b0;
  endtask

  // One full tile from load to the first IDLE cycle after tile_done.
  task automatic run_tile(input int base, input int stride, input int nfe, input int size,
                          input int ld, input bit chk);
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int c = 0; c < nfe; c++) begin
      if (chk) begin
        check("write_en", int'(write_en_o), 1);
        check("ofm_addr", int'(ofm_addr_o), base + c * stride);
        check("write_ch", int'(write_ch_o), c);
        check("write_ofm_size", int'(write_ofm_size_o), size);
        check("tile_done_early", int'(tile_done_o), 0);
      end
      tick();
    end
    if (chk) begin
      check("write_en_off", int'(write_en_o), 0);
      check("tile_done", int'(tile_done_o), 1);
      check("layer_done", int'(layer_done_o), ld);
    end
    tick();
    if (chk) check("busy_after_tile", int'(busy_o), 0);
  endtask

  initial begin
    int wcnt;
    int tcnt;
    vecs[0] = '{13, 0,    16, 1,  0,    13, 0};
    vecs[1] = '{26, 1000, 16, 1,  1000, 16, 0};
    vecs[2] = '{26, 1000, 16, 2,  1026, 16, 0};
    vecs[3] = '{26, 1000, 16, 27, 1016, 10, 0};
    vecs[4] = '{26, 1000, 16, 52, 1666, 10, 1};
    vecs[5] = '{13, 0,    16, 13, 156,  13, 1};
    vecs[6] = '{26, 1000, 5,  1,  1000, 16, 0};
    vecs[7] = '{13, 50,   0,  1,  50,   13, 0};

    rst = 1'b1; start_i = 1'b0; load_i = 1'b0;
    start_write_addr_i = '0; ofm_size_i = '0; num_filter_i = '0;
    #12;
    check("rst_ofm_addr", int'(ofm_addr_o), 0);
    check("rst_write_en", int'(write_en_o), 0);
    check("rst_wsize", int'(write_ofm_size_o), 0);
    check("rst_ch", int'(write_ch_o), 0);
    check("rst_count", int'(count_tiling_o), 1);
    check("rst_tile_done", int'(tile_done_o), 0);
    check("rst_busy", int'(busy_o), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      int nfe;
      nfe = (vecs[v].nf == 0) ? 1 : vecs[v].nf;
      do_start(vecs[v].ofm, vecs[v].saddr, vecs[v].nf);
      for (int k = 1; k < vecs[v].tile; k++)
        run_tile(0, 0, nfe, 0, 0, 1'b0);
      check("count_before", int'(count_tiling_o), vecs[v].tile);
      run_tile(vecs[v].exp_addr, vecs[v].ofm * vecs[v].ofm, nfe, vecs[v].exp_size,
               vecs[v].exp_ld, 1'b1);
      if (vecs[v].exp_ld != 0) begin
        check("count_wrap", int'(count_tiling_o), 1);
        run_tile(vecs[v].saddr, vecs[v].ofm * vecs[v].ofm, nfe,
                 (vecs[v].ofm < SS) ? vecs[v].ofm : SS, 0, 1'b1);
      end
    end

    // async reset in the middle of a WRITE cycle
    do_start(26, 1000, 16);
    load_i = 1'b1; tick(); load_i = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_write_en", int'(write_en_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_ofm_addr", int'(ofm_addr_o), 0);
    check("arst_ch", int'(write_ch_o), 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_count", int'(count_tiling_o), 1);

    // load during WRITE is ignored
    do_start(13, 0, 5);
    load_i = 1'b1; tick(); load_i = 1'b0;
    wcnt = 0; tcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (write_en_o) wcnt++;
      if (tile_done_o) tcnt++;
      load_i = (i == 1);
      tick();
    end
    load_i = 1'b0;
    check("coll_writes", wcnt, 5);
    check("coll_tile_done", tcnt, 1);
    check("coll_count", int'(count_tiling_o), 2);

    // start at the 3rd WRITE cycle aborts the tile
    do_start(26, 1000, 16);
    load_i = 1'b1; tick(); load_i = 1'b0;
    tick(); tick();
    check("abort_pre_we", int'(write_en_o), 1);
    check("abort_pre_ch", int'(write_ch_o), 2);
    start_write_addr_i = AW'(2000);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("abort_we", int'(write_en_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_count", int'(count_tiling_o), 1);
    tcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (tile_done_o || layer_done_o) tcnt++;
      tick();
    end
    check("abort_no_done", tcnt, 0);
    run_tile(2000, 676, 16, 16, 0, 1'b1);

    // start and load in the same IDLE cycle
    start_write_addr_i = AW'(300);
    start_i = 1'b1; load_i = 1'b1; tick(); start_i = 1'b0; load_i = 1'b0;
    check("sl_busy", int'(busy_o), 0);
    check("sl_we", int'(write_en_o), 0);
    run_tile(300, 676, 16, 16, 0, 1'b1);

`ifdef OFM_WR_BOUNDS_CHECK_EN
    do_start(26, RAM - 100, 16);
    check("be_clear", int'(addr_error_o), 0);
    load_i = 1'b1; tick(); load_i = 1'b0;
    check("be_ch0_we", int'(write_en_o), 1);
    check("be_ch0_err", int'(addr_error_o), 0);
    tick();
    check("be_ch1_we", int'(write_en_o), 0);
    check("be_ch1_addr", int'(ofm_addr_o), RAM - 100 + 676);
    tick();
    check("be_ch2_we", int'(write_en_o), 0);
    check("be_err", int'(addr_error_o), 1);
    for (int i = 0; i < 14; i++) tick();
    check("be_tile_done", int'(tile_done_o), 1);
    tick();
    check("be_sticky", int'(addr_error_o), 1);
    do_start(26, 0, 16);
    check("be_start_clr", int'(addr_error_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
